// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency memory between instruction fetch and data access.
// Data has priority over fetch, but a streak counter forces a fetch grant so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              stall_if,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam int DATA_W = 32;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  owner_t              resp_owner_p1, resp_owner_nxt;
  logic [3:0]          streak_p1, streak_nxt;
  logic [DATA_W-1:0]   if_hold_p1, d_hold_p1;
  logic                force_if;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= LIMIT) sat_inc = LIMIT;
    else            sat_inc = v + 4'd1;
  endfunction

  // Stage p0: combinational grant and memory drive
  assign force_if = (streak_p1 == LIMIT);
  assign d_gnt    = d_req & ~(if_req & force_if);
  assign if_gnt   = if_req & ~d_gnt;
  assign stall_if = if_req & ~if_gnt;
  assign mem_en   = if_gnt | d_gnt;
  assign mem_addr = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
  assign mem_we   = d_gnt ? d_we : 4'd0;
  assign mem_din  = d_gnt ? d_wdata : '0;

  always_comb begin
    streak_nxt     = streak_p1;
    resp_owner_nxt = OWN_NONE;
    if (if_gnt)                      resp_owner_nxt = OWN_FETCH;
    else if (d_gnt && d_we == 4'd0)  resp_owner_nxt = OWN_DATA;
    if (if_gnt || !if_req)           streak_nxt = 4'd0;
    else if (d_gnt)                  streak_nxt = sat_inc(streak_p1);
  end

  // Stage p1: response tag and streak state
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_p1     <= 4'd0;
      resp_owner_p1 <= OWN_NONE;
    end else begin
      streak_p1     <= streak_nxt;
      resp_owner_p1 <= resp_owner_nxt;
    end
  end

  // Hold registers keep the last returned word visible after rvalid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold_p1 <= '0;
      d_hold_p1  <= '0;
    end else begin
      if (resp_owner_p1 == OWN_FETCH) if_hold_p1 <= mem_dout;
      if (resp_owner_p1 == OWN_DATA)  d_hold_p1  <= mem_dout;
    end
  end

  assign if_rvalid = (resp_owner_p1 == OWN_FETCH);
  assign d_rvalid  = (resp_owner_p1 == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_dout : if_hold_p1;
  assign d_rdata   = d_rvalid  ? mem_dout : d_hold_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table plus random traffic against a behavioural model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst, if_req, d_req;
  logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
  logic [3:0]        d_we, mem_we;
  logic [31:0]       d_wdata, mem_din, mem_dout, if_rdata, d_rdata;
  logic              if_gnt, if_rvalid, stall_if, d_gnt, d_rvalid, mem_en;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .stall_if(stall_if),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: consecutive data wins over a waiting fetch,
  // who gets the read data next cycle, and the last word each side saw.
  int          m_streak;
  int          m_owner;     // 0 none, 1 fetch, 2 data
  logic [31:0] m_if_word, m_d_word;
  bit          m_known = 0;

  // Sampled actuals from the most recent step
  logic        a_ig, a_dg, a_irv, a_drv;
  logic [13:0] a_addr;
  logic [3:0]  a_we;
  logic [31:0] a_din, a_ird, a_drd;

  typedef struct {
    logic        rst, ir;
    logic [13:0] ia;
    logic        dr;
    logic [13:0] da;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        eig, edg;
    logic [13:0] eaddr;
    logic [3:0]  ewe;
    logic [31:0] edin;
    logic        eirv, edrv;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic ir, input logic [13:0] ia, input logic dr,
                     input logic [13:0] da, input logic [3:0] we, input logic [31:0] wd,
                     input logic eig, input logic edg, input logic [13:0] eaddr,
                     input logic [3:0] ewe, input logic [31:0] edin,
                     input logic eirv, input logic edrv);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.we = we; v.wd = wd;
    v.eig = eig; v.edg = edg; v.eaddr = eaddr; v.ewe = ewe; v.edin = edin;
    v.eirv = eirv; v.edrv = edrv;
    tv.push_back(v);
  endtask

  // One clock cycle: drive, check against the model, advance the model at the edge.
  task automatic step(input logic r, input logic ir, input logic [13:0] ia, input logic dr,
                      input logic [13:0] da, input logic [3:0] we, input logic [31:0] wd);
    logic        e_dg, e_ig;
    logic [31:0] dout;
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_addr = da; d_we = we; d_wdata = wd;
    dout = $urandom;
    mem_dout = dout;
    e_dg = dr && !(ir && m_streak >= LIMIT);
    e_ig = ir && !e_dg;
    #2;
    a_ig = if_gnt; a_dg = d_gnt; a_addr = mem_addr; a_we = mem_we; a_din = mem_din;
    a_irv = if_rvalid; a_drv = d_rvalid; a_ird = if_rdata; a_drd = d_rdata;
    chk("if_gnt", 32'(if_gnt), 32'(e_ig));
    chk("d_gnt", 32'(d_gnt), 32'(e_dg));
    chk("stall_if", 32'(stall_if), 32'(ir && !e_ig));
    chk("mem_en", 32'(mem_en), 32'(e_ig || e_dg));
    chk("mem_addr", 32'(mem_addr), e_dg ? 32'(da) : (e_ig ? 32'(ia) : 32'd0));
    chk("mem_we", 32'(mem_we), e_dg ? 32'(we) : 32'd0);
    chk("mem_din", mem_din, e_dg ? wd : 32'd0);
    if (m_known) begin
      chk("if_rvalid", 32'(if_rvalid), 32'(m_owner == 1));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_owner == 2));
      chk("if_rdata", if_rdata, (m_owner == 1) ? dout : m_if_word);
      chk("d_rdata", d_rdata, (m_owner == 2) ? dout : m_d_word);
    end
    @(posedge clk);
    if (r) begin
      m_streak = 0; m_owner = 0; m_if_word = 0; m_d_word = 0; m_known = 1;
    end else begin
      if (m_owner == 1) m_if_word = dout;
      if (m_owner == 2) m_d_word = dout;
      m_owner  = e_ig ? 1 : ((e_dg && we == 4'd0) ? 2 : 0);
      m_streak = (e_dg && ir) ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
    end
    #1;
  endtask

  initial begin
    m_streak = 0; m_owner = 0; m_if_word = 0; m_d_word = 0;
    rst = 1'b1; if_req = 0; d_req = 0; if_addr = 0; d_addr = 0; d_we = 0; d_wdata = 0; mem_dout = 0;

    //   rst ir ia      dr da       we    wd            eig edg addr     we    din           irv drv
    add(1, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        0, 0);
    add(0, 1, 14'd5,  0, 14'd0,   4'd0, 32'd0,        1, 0, 14'd5,   4'd0, 32'd0,        0, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        1, 0);
    add(0, 1, 14'd7,  1, 14'h10,  4'd0, 32'd0,        0, 1, 14'h10,  4'd0, 32'd0,        0, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        0, 1);
    add(0, 0, 14'd0,  1, 14'd3,   4'h3, 32'hDEADBEEF, 0, 1, 14'd3,   4'h3, 32'hDEADBEEF, 0, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        0, 0);
    add(0, 1, 14'd7,  1, 14'd9,   4'd0, 32'd0,        0, 1, 14'd9,   4'd0, 32'd0,        0, 0);
    add(0, 1, 14'd7,  1, 14'd9,   4'd0, 32'd0,        0, 1, 14'd9,   4'd0, 32'd0,        0, 1);
    add(0, 1, 14'd7,  1, 14'd9,   4'd0, 32'd0,        0, 1, 14'd9,   4'd0, 32'd0,        0, 1);
    add(0, 1, 14'd7,  1, 14'd9,   4'd0, 32'd0,        0, 1, 14'd9,   4'd0, 32'd0,        0, 1);
    add(0, 1, 14'd7,  1, 14'd9,   4'd0, 32'd0,        1, 0, 14'd7,   4'd0, 32'd0,        0, 1);
    add(0, 1, 14'd7,  1, 14'd9,   4'd0, 32'd0,        0, 1, 14'd9,   4'd0, 32'd0,        1, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        0, 1);
    add(0, 1, 14'd1,  0, 14'd0,   4'd0, 32'd0,        1, 0, 14'd1,   4'd0, 32'd0,        0, 0);
    add(0, 1, 14'd2,  0, 14'd0,   4'd0, 32'd0,        1, 0, 14'd2,   4'd0, 32'd0,        1, 0);
    add(0, 1, 14'd3,  0, 14'd0,   4'd0, 32'd0,        1, 0, 14'd3,   4'd0, 32'd0,        1, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        1, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        0, 0);
    add(1, 0, 14'd0,  1, 14'd4,   4'd0, 32'd0,        0, 1, 14'd4,   4'd0, 32'd0,        0, 0);
    add(0, 0, 14'd0,  0, 14'd0,   4'd0, 32'd0,        0, 0, 14'd0,   4'd0, 32'd0,        0, 0);

    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].ir, tv[i].ia, tv[i].dr, tv[i].da, tv[i].we, tv[i].wd);
      chk($sformatf("tv%0d.if_gnt", i),    32'(a_ig),   32'(tv[i].eig));
      chk($sformatf("tv%0d.d_gnt", i),     32'(a_dg),   32'(tv[i].edg));
      chk($sformatf("tv%0d.mem_addr", i),  32'(a_addr), 32'(tv[i].eaddr));
      chk($sformatf("tv%0d.mem_we", i),    32'(a_we),   32'(tv[i].ewe));
      chk($sformatf("tv%0d.mem_din", i),   a_din,       tv[i].edin);
      chk($sformatf("tv%0d.if_rvalid", i), 32'(a_irv),  32'(tv[i].eirv));
      chk($sformatf("tv%0d.d_rvalid", i),  32'(a_drv),  32'(tv[i].edrv));
    end
    chk("post_rst_d_rdata", a_drd, 32'd0);
    chk("post_rst_if_rdata", a_ird, 32'd0);

    for (int k = 0; k < 400; k++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      step(r, ($urandom_range(0, 3) != 0) && !r, 14'($urandom), ($urandom_range(0, 3) != 0) && !r,
           14'($urandom), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
